// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and
// the request legality check.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    LOAD     = 2'b01,
    RMW_READ = 2'b10,
    WRITE    = 2'b11
  } lsu_state_t;

  // A request is illegal for a reserved size, a misaligned half/word, or an
  // address whose 4-byte window runs past the end of memory. The range test
  // is done by the caller because it depends on the address width.
  function automatic logic access_error(input logic [1:0] size,
                                        input logic [1:0] addr_lo,
                                        input logic       out_of_range);
    logic bad;
    bad = 1'b0;
    if (size == SIZE_BAD) bad = 1'b1;
    if ((size == SIZE_HALF) && addr_lo[0]) bad = 1'b1;
    if ((size == SIZE_WORD) && (addr_lo != 2'b00)) bad = 1'b1;
    if (out_of_range) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path of the load/store unit. The memory word holds
// bytes A..A+3 big-endian, so the addressed byte/half is always at the top.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_value,
  output logic [31:0] merge_value
);

  // Load extraction with sign/zero extension, and sub-word store merge.
  always_comb begin
    load_value  = mem_word;
    merge_value = wdata;
    case (size)
      SIZE_BYTE: begin
        load_value  = {{24{sign_ext & mem_word[31]}}, mem_word[31:24]};
        merge_value = {wdata[7:0], mem_word[23:0]};
      end
      SIZE_HALF: begin
        load_value  = {{16{sign_ext & mem_word[31]}}, mem_word[31:16]};
        merge_value = {wdata[15:0], mem_word[15:0]};
      end
      default: begin
        load_value  = mem_word;
        merge_value = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit in front of a word-wide, big-endian data memory that only
// writes whole words. Sub-word stores become a read-modify-write; every
// request gets exactly one registered response.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writedata,
  output logic              mem_writeenable,
  input  logic [31:0]       mem_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 4);

  lsu_state_t        state;
  lsu_state_t        state_next;
  logic [1:0]        op_size;
  logic              op_signed;
  logic [ADDR_W-1:0] op_addr;
  // Word to be written in WRITE: raw wdata at accept, merged word after RMW_READ.
  logic [31:0]       write_word;
  logic [31:0]       load_value;
  logic [31:0]       merge_value;
  logic              accept;
  logic              req_err;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_err   = access_error(req_size, req_addr[1:0], req_addr > LAST_ADDR);

  // Memory-side outputs decode straight from the state register so an
  // asynchronous reset drops the write strobe immediately.
  assign mem_writeenable = (state == WRITE);
  assign mem_address     = (state == IDLE) ? '0 : op_addr;
  assign mem_writedata   = (state == WRITE) ? write_word : 32'd0;

  lsu_align u_align (
    .size        (op_size),
    .sign_ext    (op_signed),
    .mem_word    (mem_data),
    .wdata       (write_word),
    .load_value  (load_value),
    .merge_value (merge_value)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; illegal requests never leave IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !req_err) begin
          if (!req_write)                 state_next = LOAD;
          else if (req_size == SIZE_WORD) state_next = WRITE;
          else                            state_next = RMW_READ;
        end
      end
      LOAD:     state_next = IDLE;
      RMW_READ: state_next = WRITE;
      WRITE:    state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Request latch, merge register and one-cycle response pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_size    <= SIZE_BYTE;
      op_signed  <= 1'b0;
      op_addr    <= '0;
      write_word <= 32'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_size    <= req_size;
            op_signed  <= req_signed;
            op_addr    <= req_addr;
            write_word <= req_wdata;
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end
          end
        end
        LOAD: begin
          resp_valid <= 1'b1;
          resp_rdata <= load_value;
        end
        RMW_READ: write_word <= merge_value;
        WRITE:    resp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
